// File: rtl/hdl_encoder_pkg.sv
// Shared constants for the 4-to-2 encoder and the decoder-side benches that pair with it.
package hdl_encoder_pkg;

  localparam logic [1:0] CODE_Y0 = 2'b00;
  localparam logic [1:0] CODE_Y1 = 2'b01;
  localparam logic [1:0] CODE_Y2 = 2'b10;
  localparam logic [1:0] CODE_Y3 = 2'b11;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/hdl_prio_enc4.sv
// Combinational 4-line priority encoder with all-zero and multi-hot flags.
module hdl_prio_enc4
  import hdl_encoder_pkg::*;
#(
  parameter int PRIO_HIGH = 1
) (
  input  logic [3:0] y,
  output logic [1:0] code,
  output logic       zero,
  output logic       multi
);

  always_comb begin
    code = CODE_Y0;
    if (PRIO_HIGH != 0) begin
      if (y[3])      code = CODE_Y3;
      else if (y[2]) code = CODE_Y2;
      else if (y[1]) code = CODE_Y1;
      else           code = CODE_Y0;
    end else begin
      if (y[0])      code = CODE_Y0;
      else if (y[1]) code = CODE_Y1;
      else if (y[2]) code = CODE_Y2;
      else if (y[3]) code = CODE_Y3;
      else           code = CODE_Y0;
    end
    zero  = (y == 4'b0000);
    // Clearing the lowest set bit leaves something only if more than one line is active.
    multi = ((y & (y - 4'd1)) != 4'b0000);
  end

endmodule

// File: rtl/hdl_encoder_4to2_reg.sv
// Registered 4-to-2 encoder with a one-entry valid/ready holding register and a
// saturating count of malformed (all-zero or multi-hot) accepted words.
module hdl_encoder_4to2_reg
  import hdl_encoder_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int PRIO_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Y0,
  input  logic             Y1,
  input  logic             Y2,
  input  logic             Y3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Q0,
  output logic             Q1,
  output logic             zero,
  output logic             multi,
  output logic [CNT_W-1:0] err_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  hold_state_t      r_state;
  logic [1:0]       r_code_p1;
  logic             r_zero_p1;
  logic             r_multi_p1;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_accept;
  logic [3:0]       w_y;
  logic [1:0]       w_enc_code;
  logic             w_enc_zero;
  logic             w_enc_multi;

  assign out_valid = (r_state == ST_FULL);
  assign in_ready  = !rst && (!out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;

  // Lines are masked when not accepting so idle/undriven inputs never reach the encoder.
  assign w_y = w_accept ? {Y3, Y2, Y1, Y0} : 4'b0000;

  hdl_prio_enc4 #(
    .PRIO_HIGH (PRIO_HIGH)
  ) u_prio_enc4 (
    .y     (w_y),
    .code  (w_enc_code),
    .zero  (w_enc_zero),
    .multi (w_enc_multi)
  );

  // Stage p0 -> p1: holding register, handshake state and error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_code_p1  <= 2'b00;
      r_zero_p1  <= 1'b0;
      r_multi_p1 <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) r_state <= ST_FULL;
        end
        ST_FULL: begin
          if (out_ready && !w_accept) r_state <= ST_EMPTY;
        end
        default: r_state <= ST_EMPTY;
      endcase
      if (w_accept) begin
        r_code_p1  <= w_enc_code;
        r_zero_p1  <= w_enc_zero;
        r_multi_p1 <= w_enc_multi;
        if (w_enc_zero || w_enc_multi) r_err_cnt <= sat_inc(r_err_cnt);
      end
    end
  end

  assign Q0        = r_code_p1[1];
  assign Q1        = r_code_p1[0];
  assign zero      = r_zero_p1;
  assign multi     = r_multi_p1;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_hdl_encoder_4to2_reg.sv
// Directed bench for hdl_encoder_4to2_reg: three instances (high priority, low
// priority, 2-bit counter) share one stimulus stream.
module tb_hdl_encoder_4to2_reg;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] y;

  logic       hi_in_ready, hi_out_valid, hi_q0, hi_q1, hi_zero, hi_multi;
  logic [7:0] hi_err;
  logic       lo_in_ready, lo_out_valid, lo_q0, lo_q1, lo_zero, lo_multi;
  logic [7:0] lo_err;
  logic       c2_in_ready, c2_out_valid, c2_q0, c2_q1, c2_zero, c2_multi;
  logic [1:0] c2_err;

  int n_cmp;
  int n_bad;

  hdl_encoder_4to2_reg #(.CNT_W(8), .PRIO_HIGH(1)) u_hi (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(hi_in_ready),
    .Y0(y[0]), .Y1(y[1]), .Y2(y[2]), .Y3(y[3]),
    .out_valid(hi_out_valid), .out_ready(out_ready),
    .Q0(hi_q0), .Q1(hi_q1), .zero(hi_zero), .multi(hi_multi), .err_count(hi_err)
  );

  hdl_encoder_4to2_reg #(.CNT_W(8), .PRIO_HIGH(0)) u_lo (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(lo_in_ready),
    .Y0(y[0]), .Y1(y[1]), .Y2(y[2]), .Y3(y[3]),
    .out_valid(lo_out_valid), .out_ready(out_ready),
    .Q0(lo_q0), .Q1(lo_q1), .zero(lo_zero), .multi(lo_multi), .err_count(lo_err)
  );

  hdl_encoder_4to2_reg #(.CNT_W(2), .PRIO_HIGH(1)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c2_in_ready),
    .Y0(y[0]), .Y1(y[1]), .Y2(y[2]), .Y3(y[3]),
    .out_valid(c2_out_valid), .out_ready(out_ready),
    .Q0(c2_q0), .Q1(c2_q1), .zero(c2_zero), .multi(c2_multi), .err_count(c2_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] y;
    logic [1:0] q_hi;
    logic [1:0] q_lo;
    logic       zero;
    logic       multi;
    logic [7:0] err;
    logic [1:0] err_c2;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{4'b0001, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'd0};
    vecs[1] = '{4'b0010, 2'b01, 2'b01, 1'b0, 1'b0, 8'd0, 2'd0};
    vecs[2] = '{4'b0100, 2'b10, 2'b10, 1'b0, 1'b0, 8'd0, 2'd0};
    vecs[3] = '{4'b1000, 2'b11, 2'b11, 1'b0, 1'b0, 8'd0, 2'd0};
    vecs[4] = '{4'b1010, 2'b11, 2'b01, 1'b0, 1'b1, 8'd1, 2'd1};
    vecs[5] = '{4'b0000, 2'b00, 2'b00, 1'b1, 1'b0, 8'd2, 2'd2};
    vecs[6] = '{4'b1111, 2'b11, 2'b00, 1'b0, 1'b1, 8'd3, 2'd3};
    vecs[7] = '{4'b0110, 2'b10, 2'b01, 1'b0, 1'b1, 8'd4, 2'd3};
    vecs[8] = '{4'b1100, 2'b11, 2'b10, 1'b0, 1'b1, 8'd5, 2'd3};

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    y = 4'b0000;

    step();
    step();
    chk("rst_out_valid", {31'd0, hi_out_valid}, 32'd0);
    chk("rst_q", {30'd0, hi_q0, hi_q1}, 32'd0);
    chk("rst_flags", {30'd0, hi_zero, hi_multi}, 32'd0);
    chk("rst_err", {24'd0, hi_err}, 32'd0);
    chk("rst_in_ready", {31'd0, hi_in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, hi_in_ready}, 32'd1);

    // Back-to-back stream, one word per cycle
    for (int i = 0; i < 9; i++) begin
      y = vecs[i].y;
      in_valid = 1'b1;
      step();
      chk($sformatf("v%0d_out_valid", i), {31'd0, hi_out_valid}, 32'd1);
      chk($sformatf("v%0d_q_hi", i), {30'd0, hi_q0, hi_q1}, {30'd0, vecs[i].q_hi});
      chk($sformatf("v%0d_q_lo", i), {30'd0, lo_q0, lo_q1}, {30'd0, vecs[i].q_lo});
      chk($sformatf("v%0d_zero", i), {31'd0, hi_zero}, {31'd0, vecs[i].zero});
      chk($sformatf("v%0d_multi", i), {31'd0, hi_multi}, {31'd0, vecs[i].multi});
      chk($sformatf("v%0d_err", i), {24'd0, hi_err}, {24'd0, vecs[i].err});
      chk($sformatf("v%0d_err_c2", i), {30'd0, c2_err}, {30'd0, vecs[i].err_c2});
      if (!vecs[i].zero && !vecs[i].multi) begin
        logic [3:0] dec;
        dec = 4'b0001 << {hi_q0, hi_q1};
        chk($sformatf("v%0d_roundtrip", i), {28'd0, dec}, {28'd0, vecs[i].y});
      end
    end
    in_valid = 1'b0;
    y = 4'b1111;
    step();
    chk("drain_out_valid", {31'd0, hi_out_valid}, 32'd0);
    chk("idle_err_hold", {24'd0, hi_err}, 32'd5);

    // Backpressure: held result stays stable, stalled bad word not counted
    y = 4'b0100;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    y = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d_out_valid", k), {31'd0, hi_out_valid}, 32'd1);
      chk($sformatf("bp%0d_q", k), {30'd0, hi_q0, hi_q1}, 32'd2);
      chk($sformatf("bp%0d_multi", k), {31'd0, hi_multi}, 32'd0);
      chk($sformatf("bp%0d_in_ready", k), {31'd0, hi_in_ready}, 32'd0);
      chk($sformatf("bp%0d_err", k), {24'd0, hi_err}, 32'd5);
      step();
    end
    out_ready = 1'b1;
    y = 4'b0001;
    #1;
    chk("bp_release_in_ready", {31'd0, hi_in_ready}, 32'd1);
    step();
    chk("bp_reload_out_valid", {31'd0, hi_out_valid}, 32'd1);
    chk("bp_reload_q", {30'd0, hi_q0, hi_q1}, 32'd0);
    chk("bp_reload_err", {24'd0, hi_err}, 32'd5);
    in_valid = 1'b0;
    step();
    chk("bp_drain_out_valid", {31'd0, hi_out_valid}, 32'd0);

    // Reset while FULL drops the held result and clears the counter
    y = 4'b0010;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    chk("rf_full", {31'd0, hi_out_valid}, 32'd1);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rf_in_ready_in_rst", {31'd0, hi_in_ready}, 32'd0);
    step();
    chk("rf_out_valid", {31'd0, hi_out_valid}, 32'd0);
    chk("rf_err", {24'd0, hi_err}, 32'd0);
    chk("rf_err_c2", {30'd0, c2_err}, 32'd0);
    chk("rf_q", {30'd0, hi_q0, hi_q1}, 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rf_in_ready_after", {31'd0, hi_in_ready}, 32'd1);
    step();
    chk("rf_idle_out_valid", {31'd0, hi_out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
